// File: rtl/hust_efi_pkg.sv
// Shared engine-timing definitions: stroke encodings, generator states and period defaults.
package hust_efi_pkg;

    typedef enum logic [1:0] {
        STROKE_INTAKE      = 2'b00,
        STROKE_COMPRESSION = 2'b01,
        STROKE_COMBUSTION  = 2'b10,
        STROKE_EXHAUST     = 2'b11
    } stroke_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPINUP,
        ST_RUN
    } gen_state_e;

    localparam logic [15:0] DEFAULT_TOOTH_PERIOD     = 16'd1000;
    localparam logic [15:0] MIN_TOOTH_PERIOD         = 16'd2;
    localparam int          DEFAULT_TEETH_PER_STROKE = 12;

    // A period below two cycles cannot produce separated one-cycle pulses.
    function automatic logic [15:0] clamp_period(input logic [15:0] period);
        return (period < MIN_TOOTH_PERIOD) ? MIN_TOOTH_PERIOD : period;
    endfunction

endpackage

// File: rtl/tooth_timer.sv
// Per-tooth down-counter with pending/active period registers; expire marks the last cycle of a tooth.
module tooth_timer
    import hust_efi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        start,
    input  logic [15:0] tooth_period,
    input  logic        period_load,
    output logic        expire
);

    logic [15:0] count_q;
    logic [15:0] pending_q;
    logic [15:0] active_q;
    logic [15:0] load_value;
    logic [15:0] next_period;

    assign load_value  = clamp_period(tooth_period);
    assign next_period = period_load ? load_value : pending_q;
    assign expire      = run && (count_q == 16'd0);

    // While stopped there is no tooth in progress, so the active period tracks the pending one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= 16'd0;
            pending_q <= DEFAULT_TOOTH_PERIOD;
            active_q  <= DEFAULT_TOOTH_PERIOD;
        end else begin
            if (period_load) begin
                pending_q <= load_value;
            end
            if (start) begin
                count_q <= active_q - 16'd1;
            end else if (expire) begin
                active_q <= next_period;
                count_q  <= next_period - 16'd1;
            end else if (run) begin
                count_q <= count_q - 16'd1;
            end else begin
                count_q  <= 16'd0;
                active_q <= next_period;
            end
        end
    end

endmodule

// File: rtl/crank_signal_gen.sv
// Crank/cam signal generator: tooth and stroke sequencing with registered pulse outputs.
// Define CRANK_GEN_MISSING_TOOTH_EN to drop the last tick of every revolution.
module crank_signal_gen
    import hust_efi_pkg::*;
#(
    parameter int TEETH_PER_STROKE = DEFAULT_TEETH_PER_STROKE
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        on,
    input  logic [15:0] tooth_period,
    input  logic        period_load,
    input  logic [1:0]  start_stroke,
    output logic        crank_tick,
    output logic        crank_changed,
    output logic        ckp,
    output logic [1:0]  stroke_idx,
    output logic [5:0]  tooth_idx
);

    localparam logic [5:0] LAST_TOOTH = 6'(TEETH_PER_STROKE - 1);

    gen_state_e  state_q;
    gen_state_e  state_d;
    logic [1:0]  stroke_d;
    logic [5:0]  tooth_d;
    logic        tick_d;
    logic        changed_d;
    logic        ckp_d;
    logic        run;
    logic        start;
    logic        expire;

    assign run   = on && (state_q != ST_IDLE);
    assign start = on && (state_q == ST_IDLE);

    tooth_timer u_tooth_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .start        (start),
        .tooth_period (tooth_period),
        .period_load  (period_load),
        .expire       (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            stroke_idx    <= 2'b00;
            tooth_idx     <= 6'd0;
            crank_tick    <= 1'b0;
            crank_changed <= 1'b0;
            ckp           <= 1'b0;
        end else begin
            state_q       <= state_d;
            stroke_idx    <= stroke_d;
            tooth_idx     <= tooth_d;
            crank_tick    <= tick_d;
            crank_changed <= changed_d;
            ckp           <= ckp_d;
        end
    end

    // Starting at the last tooth makes the first tick the opening tooth of the next stroke.
    always_comb begin
        state_d   = state_q;
        stroke_d  = stroke_idx;
        tooth_d   = tooth_idx;
        tick_d    = 1'b0;
        changed_d = 1'b0;
        if (!on) begin
            state_d  = ST_IDLE;
            stroke_d = 2'b00;
            tooth_d  = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SPINUP;
                    stroke_d = start_stroke;
                    tooth_d  = LAST_TOOTH;
                end
                ST_SPINUP, ST_RUN: begin
                    if (expire) begin
                        state_d = ST_RUN;
                        tick_d  = 1'b1;
                        if (tooth_idx == LAST_TOOTH) begin
                            tooth_d   = 6'd0;
                            stroke_d  = stroke_idx + 2'd1;
                            changed_d = 1'b1;
                        end else begin
                            tooth_d = tooth_idx + 6'd1;
                        end
`ifdef CRANK_GEN_MISSING_TOOTH_EN
                        if ((tooth_d == LAST_TOOTH) &&
                            ((stroke_d == STROKE_COMPRESSION) || (stroke_d == STROKE_EXHAUST))) begin
                            tick_d = 1'b0;
                        end
`else
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        ckp_d = (state_d != ST_IDLE) &&
                ((stroke_d == STROKE_INTAKE) || (stroke_d == STROKE_COMPRESSION));
    end

endmodule

// File: tb/tb_crank_signal_gen.sv
// Directed self-checking bench for crank_signal_gen (honours CRANK_GEN_MISSING_TOOTH_EN when defined).
module tb_crank_signal_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        on;
    logic [15:0] tooth_period;
    logic        period_load;
    logic [1:0]  start_stroke;
    logic        crank_tick;
    logic        crank_changed;
    logic        ckp;
    logic [1:0]  stroke_idx;
    logic [5:0]  tooth_idx;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    crank_signal_gen #(.TEETH_PER_STROKE(12)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .on            (on),
        .tooth_period  (tooth_period),
        .period_load   (period_load),
        .start_stroke  (start_stroke),
        .crank_tick    (crank_tick),
        .crank_changed (crank_changed),
        .ckp           (ckp),
        .stroke_idx    (stroke_idx),
        .tooth_idx     (tooth_idx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int tick, input int changed, input int cam,
                            input int stroke, input int tooth);
        checkOutput({tag, "_tick"},    crank_tick,    tick);
        checkOutput({tag, "_changed"}, crank_changed, changed);
        checkOutput({tag, "_ckp"},     ckp,           cam);
        checkOutput({tag, "_stroke"},  stroke_idx,    stroke);
        checkOutput({tag, "_tooth"},   tooth_idx,     tooth);
    endtask

    task automatic applyStimulus(input logic en, input logic load, input logic [15:0] period,
                                 input logic [1:0] stroke);
        on           = en;
        period_load  = load;
        tooth_period = period;
        start_stroke = stroke;
    endtask

    task automatic stepClock(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stepCountTicks(input int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (crank_tick === 1'b1) ticks++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stray;
        int exp_tooth, exp_stroke, exp_tick, exp_changed, exp_ckp;

        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'd0, 2'b00);
        #12;
        checkAll("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        stepClock(1);

        // 10-cycle teeth from INTAKE across four strokes
        applyStimulus(1'b0, 1'b1, 16'd10, 2'b00);
        stepClock(1);
        applyStimulus(1'b1, 1'b0, 16'd10, 2'b00);
        stepClock(1);
        checkAll("spinup", 0, 0, 1, 0, 11);
        for (int n = 1; n <= 48; n++) begin
            stepCountTicks(9, stray);
            checkOutput($sformatf("stray_tooth%0d", n), stray, 0);
            stepClock(1);
            exp_tooth   = (n - 1) % 12;
            exp_stroke  = ((n - 1) / 12 + 1) % 4;
            exp_tick    = 1;
`ifdef CRANK_GEN_MISSING_TOOTH_EN
            if (exp_tooth == 11 && (exp_stroke % 2) == 1) exp_tick = 0;
`else
`endif
            exp_changed = (exp_tooth == 0) ? 1 : 0;
            exp_ckp     = (exp_stroke < 2) ? 1 : 0;
            checkAll($sformatf("tooth%0d", n), exp_tick, exp_changed, exp_ckp, exp_stroke, exp_tooth);
        end

        // mid-tooth period change takes effect on the following tooth
        stepClock(3);
        applyStimulus(1'b1, 1'b1, 16'd20, 2'b00);
        stepClock(1);
        applyStimulus(1'b1, 1'b0, 16'd20, 2'b00);
        stepCountTicks(5, stray);
        checkOutput("old_period_stray", stray, 0);
        stepClock(1);
        checkAll("old_period", 1, 1, 1, 1, 0);
        stepCountTicks(19, stray);
        checkOutput("new_period_stray", stray, 0);
        stepClock(1);
        checkAll("new_period", 1, 0, 1, 1, 1);

        // load coinciding with the count-0 cycle applies to that reload
        stepCountTicks(19, stray);
        checkOutput("zero_load_stray", stray, 0);
        applyStimulus(1'b1, 1'b1, 16'd5, 2'b00);
        stepClock(1);
        checkAll("zero_load", 1, 0, 1, 1, 2);
        applyStimulus(1'b1, 1'b0, 16'd5, 2'b00);
        stepCountTicks(4, stray);
        checkOutput("period5_stray", stray, 0);
        stepClock(1);
        checkAll("period5", 1, 0, 1, 1, 3);

        // zero period clamps to two cycles
        stepCountTicks(4, stray);
        checkOutput("clamp_load_stray", stray, 0);
        applyStimulus(1'b1, 1'b1, 16'd0, 2'b00);
        stepClock(1);
        checkAll("clamp_load", 1, 0, 1, 1, 4);
        applyStimulus(1'b1, 1'b0, 16'd0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            stepClock(1);
            checkOutput($sformatf("clamp_gap%0d", k), crank_tick, 0);
            stepClock(1);
            checkOutput($sformatf("clamp_tick%0d", k), crank_tick, 1);
            checkOutput($sformatf("clamp_tooth%0d", k), tooth_idx, 5 + k);
        end

        // stop mid-stroke, then restart from COMBUSTION with the retained period
        applyStimulus(1'b0, 1'b0, 16'd0, 2'b10);
        stepClock(1);
        checkAll("off", 0, 0, 0, 0, 0);
        stepClock(2);
        checkAll("off_hold", 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 16'd0, 2'b10);
        stepClock(1);
        checkAll("restart", 0, 0, 0, 2, 11);
        stepClock(1);
        checkOutput("restart_gap", crank_tick, 0);
        stepClock(1);
        checkAll("restart_tick", 1, 1, 0, 3, 0);

        // asynchronous reset mid-tooth restores the 1000-cycle default
        applyStimulus(1'b1, 1'b1, 16'd10, 2'b10);
        stepClock(1);
        applyStimulus(1'b1, 1'b0, 16'd10, 2'b10);
        stepClock(4);
        reset_n = 1'b0;
        #2;
        checkAll("reset_async", 0, 0, 0, 0, 0);
        #1;
        reset_n = 1'b1;
        stepClock(1);
        checkAll("reset_spinup", 0, 0, 0, 2, 11);
        stepCountTicks(999, stray);
        checkOutput("default_period_stray", stray, 0);
        stepClock(1);
        checkAll("default_period", 1, 1, 0, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
